// File: rtl/ksa_pin_responder.sv
// Pin-level responder: collects two operands byte-wise over a strobe handshake,
// adds them with a Kogge-Stone prefix adder and returns the sum byte-wise over valid/ack.
module ksa_pin_responder #(
   parameter int WIDTH = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int NBYTES = WIDTH / 8;
   localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int STG    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NBYTES - 1);

   typedef enum logic [1:0] {LOAD_A, LOAD_B, ADD, SEND} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_nxt;
   logic [WIDTH-1:0]   a_reg;
   logic [WIDTH-1:0]   b_reg;
   logic [WIDTH-1:0]   s_reg;
   logic               cin_q;
   logic               stb_q;
   logic               ack_q;
   logic               out_valid;
   logic               busy;
   logic               cout_o;
   logic               ready_in;
   logic [WIDTH:0]     sum_p0;

   logic wr_stb, rd_ack, cin, abort;
   logic wr_edge, ack_edge;
   logic unused_bits;

   assign wr_stb      = uio_in[0];
   assign rd_ack      = uio_in[1];
   assign cin         = uio_in[2];
   assign abort       = uio_in[3];
   assign unused_bits = ^uio_in[7:4];

   assign wr_edge  = wr_stb & ~stb_q;
   assign ack_edge = rd_ack & ~ack_q;
   assign cnt_nxt  = cnt + 1'b1;

   assign uio_out = {ready_in, cout_o, busy, out_valid, 4'b0000};
   assign uio_oe  = 8'hF0;

   // Kogge-Stone: cin folded into bit-0 generate, then log2(WIDTH) doubling-distance prefix stages.
   function automatic logic [WIDTH:0] ks_add(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic             c);
      logic [WIDTH-1:0] p0, g, p, gn, pn;
      p0   = a ^ b;
      g    = a & b;
      p    = p0;
      g[0] = g[0] | (p0[0] & c);
      for (int s = 0; s < STG; s++) begin
         gn = g;
         pn = p;
         for (int i = (1 << s); i < WIDTH; i++) begin
            gn[i] = g[i] | (p[i] & g[i - (1 << s)]);
            pn[i] = p[i] & p[i - (1 << s)];
         end
         g = gn;
         p = pn;
      end
      return {g[WIDTH-1], p0 ^ {g[WIDTH-2:0], c}};
   endfunction

   always_comb sum_p0 = ks_add(a_reg, b_reg, cin_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= LOAD_A;
         cnt       <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         s_reg     <= '0;
         cin_q     <= 1'b0;
         stb_q     <= 1'b0;
         ack_q     <= 1'b0;
         uo_out    <= 8'h00;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         cout_o    <= 1'b0;
         ready_in  <= 1'b1;
      end else if (ena) begin
         stb_q <= wr_stb;
         ack_q <= rd_ack;
         if (abort) begin
            state     <= LOAD_A;
            cnt       <= '0;
            uo_out    <= 8'h00;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            cout_o    <= 1'b0;
            ready_in  <= 1'b1;
         end else begin
            case (state)
               LOAD_A: begin
                  if (wr_edge) begin
                     a_reg[{cnt, 3'b000} +: 8] <= ui_in;
                     if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= LOAD_B;
                     end else begin
                        cnt <= cnt_nxt;
                     end
                  end
               end
               LOAD_B: begin
                  if (wr_edge) begin
                     b_reg[{cnt, 3'b000} +: 8] <= ui_in;
                     if (cnt == LAST) begin
                        cnt      <= '0;
                        cin_q    <= cin;
                        ready_in <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ADD;
                     end else begin
                        cnt <= cnt_nxt;
                     end
                  end
               end
               // Sum is registered and byte 0 presented in the same edge, so valid rises one cycle after ADD.
               ADD: begin
                  s_reg     <= sum_p0[WIDTH-1:0];
                  cout_o    <= sum_p0[WIDTH];
                  uo_out    <= sum_p0[7:0];
                  out_valid <= 1'b1;
                  cnt       <= '0;
                  state     <= SEND;
               end
               SEND: begin
                  if (ack_edge) begin
                     if (cnt == LAST) begin
                        cnt       <= '0;
                        uo_out    <= 8'h00;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        cout_o    <= 1'b0;
                        ready_in  <= 1'b1;
                        state     <= LOAD_A;
                     end else begin
                        cnt    <= cnt_nxt;
                        uo_out <= s_reg[{cnt_nxt, 3'b000} +: 8];
                     end
                  end
               end
               default: state <= LOAD_A;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ksa_pin_responder.sv
// Directed and randomized bench for ksa_pin_responder; expected sums come from plain integer addition.
module tb_ksa_pin_responder;

   localparam int W  = 16;
   localparam int NB = W / 8;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int vecs = 0;
   int miss = 0;

   ksa_pin_responder #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      vecs++;
      assert (obs === exp_v) else begin
         miss++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      ui_in     = b;
      uio_in[0] = 1'b1;
      tick();
      uio_in[0] = 1'b0;
      tick();
   endtask

   task automatic pulse_ack();
      uio_in[1] = 1'b1;
      tick();
      uio_in[1] = 1'b0;
      tick();
   endtask

   task automatic load_a(input logic [W-1:0] a);
      for (int k = 0; k < NB; k++) send_byte(a[8*k +: 8]);
   endtask

   // Loads B; the last strobe is inlined to check the two-cycle valid latency.
   task automatic load_b(input logic [W-1:0] b, input logic c);
      uio_in[2] = c;
      for (int k = 0; k < NB - 1; k++) send_byte(b[8*k +: 8]);
      ui_in     = b[8*(NB-1) +: 8];
      uio_in[0] = 1'b1;
      tick();
      chk("add_cycle_status", uio_out, 8'h20);
      uio_in[0] = 1'b0;
      tick();
      chk("valid_latency", uio_out[4], 1'b1);
   endtask

   task automatic read_check(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                             input string tag);
      logic [W:0] e;
      e = {1'b0, a} + {1'b0, b} + (W+1)'(c);
      for (int k = 0; k < NB; k++) begin
         chk({tag, "_byte"}, uo_out, e[8*k +: 8]);
         chk({tag, "_status"}, uio_out, {1'b0, e[W], 2'b11, 4'b0000});
         pulse_ack();
      end
      chk({tag, "_idle_status"}, uio_out, 8'h80);
      chk({tag, "_idle_byte"}, uo_out, 8'h00);
   endtask

   task automatic txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                      input string tag);
      load_a(a);
      load_b(b, c);
      read_check(a, b, c, tag);
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      logic         rc;
      rst_n  = 1'b0;
      ena    = 1'b1;
      ui_in  = 8'h00;
      uio_in = 8'h00;
      tick();
      tick();
      chk("reset_uo_out", uo_out, 8'h00);
      chk("reset_uio_out", uio_out, 8'h80);
      chk("uio_oe", uio_oe, 8'hF0);
      rst_n = 1'b1;
      tick();

      txn(16'h1234, 16'h0FCD, 1'b0, "t1");
      txn(16'hFFFF, 16'h0001, 1'b0, "t2a");
      txn(16'hFFFF, 16'h0000, 1'b1, "t2b");

      // Held strobe counts once; strobes during SEND are ignored.
      ui_in     = 8'h34;
      uio_in[0] = 1'b1;
      repeat (5) tick();
      uio_in[0] = 1'b0;
      tick();
      chk("held_stb_ready", uio_out, 8'h80);
      send_byte(8'h12);
      load_b(16'h0101, 1'b0);
      send_byte(8'hAA);
      send_byte(8'h55);
      chk("send_stb_ignored", uo_out, 8'h35);
      read_check(16'h1234, 16'h0101, 1'b0, "t3");

      // Reset after three operand bytes.
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      rst_n = 1'b0;
      #1;
      chk("midreset_uio_out", uio_out, 8'h80);
      chk("midreset_uo_out", uo_out, 8'h00);
      tick();
      rst_n = 1'b1;
      tick();
      txn(16'h0001, 16'h0001, 1'b0, "t4");

      // ena=0 freezes the byte index; acks seen while disabled are lost.
      load_a(16'hBEEF);
      load_b(16'h1111, 1'b0);
      ena       = 1'b0;
      uio_in[1] = 1'b1;
      tick();
      uio_in[1] = 1'b0;
      tick();
      ena = 1'b1;
      tick();
      chk("ena_freeze_byte", uo_out, 8'h00);
      chk("ena_freeze_status", uio_out, 8'h30);
      read_check(16'hBEEF, 16'h1111, 1'b0, "t5");

      // Abort in SEND, then a clean transaction.
      load_a(16'h1111);
      load_b(16'h2222, 1'b0);
      uio_in[3] = 1'b1;
      tick();
      uio_in[3] = 1'b0;
      chk("abort_status", uio_out, 8'h80);
      chk("abort_byte", uo_out, 8'h00);
      txn(16'hABCD, 16'h1234, 1'b1, "t6");

      for (int n = 0; n < 24; n++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom_range(0, 1));
         if (n == 0) begin
            ra = 16'hFFFF;
            rb = 16'hFFFF;
            rc = 1'b1;
         end
         txn(ra, rb, rc, "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

endmodule
